// File: rtl/req_resp_seq_checker.sv
// req_resp_seq_checker
// Multi-channel temporal checker for the rule "req high REQ_LEN consecutive
// cycles, then DELAY cycles later resp high RESP_LEN consecutive cycles",
// with overlapping-implication semantics: every cycle that completes a req
// run starts its own obligation thread. Thread age is tracked per channel as
// a one-hot-per-age shift register covering ages 1..L-1 (L = DELAY+RESP_LEN).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over everything)
//   dis        disable-iff: flushes run counters and threads, holds counters
//   req        [NUM_CH]        per-channel request
//   resp       [NUM_CH]        per-channel response
//   pass_pulse [NUM_CH]        registered pulse, >=1 thread passed last cycle
//   fail_pulse [NUM_CH]        registered pulse, >=1 thread failed last cycle
//   pass_cnt   [NUM_CH*CNT_W]  saturating pass counts, ch i at [i*CNT_W +: CNT_W]
//   fail_cnt   [NUM_CH*CNT_W]  saturating fail counts, same packing
//   busy       [NUM_CH]        channel holds at least one live thread
//
// Optional feature (macro REQRESP_FIRST_FAIL_LOG_EN):
//   first_fail_vld / first_fail_ch / first_fail_cyc capture the lowest failing
//   channel and a free-running 32-bit cycle count at the first failure after
//   reset, then freeze until rst.
module req_resp_seq_checker #(
  parameter int NUM_CH   = 1,
  parameter int REQ_LEN  = 2,
  parameter int DELAY    = 4,
  parameter int RESP_LEN = 2,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dis,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH-1:0]       resp,
  output logic [NUM_CH-1:0]       pass_pulse,
  output logic [NUM_CH-1:0]       fail_pulse,
  output logic [NUM_CH*CNT_W-1:0] pass_cnt,
  output logic [NUM_CH*CNT_W-1:0] fail_cnt,
  output logic [NUM_CH-1:0]       busy
`ifdef REQRESP_FIRST_FAIL_LOG_EN
  ,
  output logic                    first_fail_vld,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] first_fail_ch,
  output logic [31:0]             first_fail_cyc
`endif
);

  localparam int L    = DELAY + RESP_LEN;
  localparam int RC_W = $clog2(REQ_LEN + 1);
  localparam logic [RC_W-1:0]  RC_MAX  = RC_W'(REQ_LEN);
  localparam logic [RC_W-1:0]  RC_ARM  = RC_W'(REQ_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0][RC_W-1:0] run_q, run_d;
  logic [NUM_CH-1:0][L-1:1]    age_q, age_d;
  logic [NUM_CH-1:0]           match, pass_d, fail_d;
  logic                        win_live;

  // Next-state evaluation. A match this cycle is age 0 and can never sit in
  // the window because DELAY >= 1. With resp low every windowed thread dies
  // instead of shifting; the thread at age L-1 always leaves, passing only
  // if resp is high.
  always_comb begin
    run_d    = run_q;
    age_d    = age_q;
    match    = '0;
    pass_d   = '0;
    fail_d   = '0;
    win_live = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      match[c] = req[c] && (run_q[c] >= RC_ARM);
      if (!req[c]) begin
        run_d[c] = '0;
      end else if (run_q[c] != RC_MAX) begin
        run_d[c] = run_q[c] + 1'b1;
      end

      win_live = 1'b0;
      for (int k = DELAY; k < L; k++) begin
        win_live = win_live | age_q[c][k];
      end
      pass_d[c] = resp[c] & age_q[c][L-1];
      fail_d[c] = ~resp[c] & win_live;

      age_d[c][1] = match[c];
      for (int k = 2; k < L; k++) begin
        age_d[c][k] = age_q[c][k-1] & (resp[c] | ((k - 1) < DELAY));
      end
    end
  end

  // dis flushes all live state but deliberately leaves the counters alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q      <= '0;
      age_q      <= '0;
      pass_pulse <= '0;
      fail_pulse <= '0;
      busy       <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
    end else if (dis) begin
      run_q      <= '0;
      age_q      <= '0;
      pass_pulse <= '0;
      fail_pulse <= '0;
      busy       <= '0;
    end else begin
      run_q      <= run_d;
      age_q      <= age_d;
      pass_pulse <= pass_d;
      fail_pulse <= fail_d;
      for (int c = 0; c < NUM_CH; c++) begin
        busy[c] <= |age_d[c];
        if (pass_d[c] && (pass_cnt[c*CNT_W +: CNT_W] != CNT_MAX)) begin
          pass_cnt[c*CNT_W +: CNT_W] <= pass_cnt[c*CNT_W +: CNT_W] + 1'b1;
        end
        if (fail_d[c] && (fail_cnt[c*CNT_W +: CNT_W] != CNT_MAX)) begin
          fail_cnt[c*CNT_W +: CNT_W] <= fail_cnt[c*CNT_W +: CNT_W] + 1'b1;
        end
      end
    end
  end

`ifdef REQRESP_FIRST_FAIL_LOG_EN
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [31:0]     cyc_cnt;
  logic [CH_W-1:0] low_ch;

  // Descending scan so the lowest failing channel is the one that sticks.
  always_comb begin
    low_ch = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (fail_d[c]) begin
        low_ch = CH_W'(c);
      end
    end
  end

  // The cycle counter keeps running through dis; the log records the count
  // of the evaluation edge, which is the edge that raises fail_pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt        <= '0;
      first_fail_vld <= 1'b0;
      first_fail_ch  <= '0;
      first_fail_cyc <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (!dis && !first_fail_vld && (|fail_d)) begin
        first_fail_vld <= 1'b1;
        first_fail_ch  <= low_ch;
        first_fail_cyc <= cyc_cnt;
      end
    end
  end
`endif

endmodule
